// File: rtl/sobel_pkg.sv
// sobel_pkg: shared sizing and helper types for the Sobel window and core stages
package sobel_pkg;
  localparam int PIXEL_WIDTH = 8;
  localparam int MAX_LINE_WIDTH = 32;
  localparam int LINE_WIDTH_BITS = 6;
  localparam int MIN_LINE_WIDTH = 3;
  typedef logic [1:0] row_t;
  localparam row_t ROW_LAST = 2'd2;
endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one image line of storage, combinational read-before-write at a single index
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = PIXEL_WIDTH,
  parameter int DEPTH = MAX_LINE_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  assign rd_data = mem[idx];
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wr_data;
  end
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streams pixels through two line buffers and emits 3x3 windows for the Sobel core
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH = sobel_pkg::PIXEL_WIDTH,
  parameter int MAX_LINE_WIDTH = sobel_pkg::MAX_LINE_WIDTH,
  parameter int LINE_WIDTH_BITS = sobel_pkg::LINE_WIDTH_BITS
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [LINE_WIDTH_BITS-1:0] cfg_width_i,
  input  logic                       in_valid_i,
  input  logic                       in_sof_i,
  input  logic [PIXEL_WIDTH-1:0]     in_pixel_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PIXEL_WIDTH-1:0]     pix0_0_o,
  output logic [PIXEL_WIDTH-1:0]     pix0_1_o,
  output logic [PIXEL_WIDTH-1:0]     pix0_2_o,
  output logic [PIXEL_WIDTH-1:0]     pix1_0_o,
  output logic [PIXEL_WIDTH-1:0]     pix1_1_o,
  output logic [PIXEL_WIDTH-1:0]     pix1_2_o,
  output logic [PIXEL_WIDTH-1:0]     pix2_0_o,
  output logic [PIXEL_WIDTH-1:0]     pix2_1_o,
  output logic [PIXEL_WIDTH-1:0]     pix2_2_o
);
  localparam int AW = $clog2(MAX_LINE_WIDTH);
  localparam logic [LINE_WIDTH_BITS-1:0] W_MIN = LINE_WIDTH_BITS'(MIN_LINE_WIDTH);
  localparam logic [LINE_WIDTH_BITS-1:0] W_MAX = LINE_WIDTH_BITS'(MAX_LINE_WIDTH);
  logic [LINE_WIDTH_BITS-1:0] col, w, col_eff, w_eff, cfg_clamped;
  row_t row, row_eff;
  logic accept, last_col, qualify;
  logic [PIXEL_WIDTH-1:0] top, mid;
  logic [PIXEL_WIDTH-1:0] win [3][3];
  assign in_ready_o = !out_valid_o || out_ready_i;
  // An accepted sof pixel restarts the frame at (0,0) with a freshly latched width.
  always_comb begin
    accept = in_valid_i && in_ready_o;
    cfg_clamped = cfg_width_i < W_MIN ? W_MIN : cfg_width_i > W_MAX ? W_MAX : cfg_width_i;
    col_eff = in_sof_i ? '0 : col;
    row_eff = in_sof_i ? '0 : row;
    w_eff = in_sof_i ? cfg_clamped : w;
    last_col = col_eff == w_eff - LINE_WIDTH_BITS'(1);
    qualify = row_eff == ROW_LAST && col_eff >= LINE_WIDTH_BITS'(2);
  end
  sobel_line_buffer #(.DATA_WIDTH(PIXEL_WIDTH), .DEPTH(MAX_LINE_WIDTH)) u_line_a (
    .clk(clk_i), .we(accept), .idx(col_eff[AW-1:0]), .wr_data(in_pixel_i), .rd_data(mid)
  );
  sobel_line_buffer #(.DATA_WIDTH(PIXEL_WIDTH), .DEPTH(MAX_LINE_WIDTH)) u_line_b (
    .clk(clk_i), .we(accept), .idx(col_eff[AW-1:0]), .wr_data(mid), .rd_data(top)
  );
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col <= '0;
      row <= '0;
      w <= W_MIN;
      out_valid_o <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win[i][j] <= '0;
    end else begin
      if (accept) begin
        col <= last_col ? '0 : col_eff + LINE_WIDTH_BITS'(1);
        row <= last_col && row_eff != ROW_LAST ? row_eff + 2'd1 : row_eff;
        w <= w_eff;
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= top;
        win[1][2] <= mid;
        win[2][2] <= in_pixel_i;
      end
      out_valid_o <= accept ? qualify : out_valid_o && !out_ready_i;
    end
  end
  assign pix0_0_o = win[0][0];
  assign pix0_1_o = win[0][1];
  assign pix0_2_o = win[0][2];
  assign pix1_0_o = win[1][0];
  assign pix1_1_o = win[1][1];
  assign pix1_2_o = win[1][2];
  assign pix2_0_o = win[2][0];
  assign pix2_1_o = win[2][1];
  assign pix2_2_o = win[2][2];
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed and randomized frames checked against an image-slice window model
module tb_sobel_window_gen;
  import sobel_pkg::*;
  localparam int PW = PIXEL_WIDTH;
  localparam int LWB = LINE_WIDTH_BITS;
  logic clk, reset, in_valid, in_sof, in_ready, out_valid, out_ready;
  logic [LWB-1:0] cfg;
  logic [PW-1:0] in_pixel;
  logic [PW-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic [9*PW-1:0] win_obs, snap;
  int img [8][32];
  logic [9*PW-1:0] exp_q [$];
  int checks, errors, got, g0, ready_mode;

  sobel_window_gen dut (
    .clk_i(clk), .reset_i(reset), .cfg_width_i(cfg), .in_valid_i(in_valid), .in_sof_i(in_sof),
    .in_pixel_i(in_pixel), .in_ready_o(in_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pix0_0_o(p00), .pix0_1_o(p01), .pix0_2_o(p02), .pix1_0_o(p10), .pix1_1_o(p11),
    .pix1_2_o(p12), .pix2_0_o(p20), .pix2_1_o(p21), .pix2_2_o(p22)
  );
  assign win_obs = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9*PW-1:0] model_win(int r, int c);
    logic [9*PW-1:0] v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) v[(8 - (i * 3 + j)) * PW +: PW] = PW'(img[r - 2 + i][c - 2 + j]);
    return v;
  endfunction

  task automatic load_model(int w, int h);
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++) exp_q.push_back(model_win(r, c));
  endtask

  task automatic fill_random(int w, int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  task automatic send_pix(int p, bit sof, int max_gap);
    int n;
    n = max_gap > 0 ? int'($urandom_range(0, max_gap)) : 0;
    if (n > 0) begin
      in_valid = 0;
      repeat (n) @(posedge clk);
      #1;
    end
    in_valid = 1;
    in_pixel = PW'(p);
    in_sof = sof;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 1000);
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL send_timeout obs_ready=%0b exp_ready=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    in_sof = 0;
  endtask

  task automatic send_frame(int w, int h, int gap);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) send_pix(img[r][c], r == 0 && c == 0, gap);
  endtask

  task automatic drain(string tag);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0 && !out_valid) else begin
      errors++;
      $error("FAIL %s_drain obs_pending=%0d exp_pending=0", tag, exp_q.size());
    end
  endtask

  task automatic check_count(string tag, int expected);
    checks++;
    assert (got - g0 === expected) else begin
      errors++;
      $error("FAIL %s_count obs=%0d exp=%0d", tag, got - g0, expected);
    end
  endtask

  task automatic check_bit(string tag, logic obs, logic expected);
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("FAIL %s obs=%0b exp=%0b", tag, obs, expected);
    end
  endtask

  task automatic check_win(string tag, logic [9*PW-1:0] expected);
    checks++;
    assert (win_obs === expected) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, win_obs, expected);
    end
  endtask

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode[0];
    end
  end

  // Every handshaked window must be the oldest outstanding window of the model.
  initial forever begin
    @(negedge clk);
    if (!reset && out_valid && out_ready) begin
      got++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_window obs=%h exp=none", win_obs);
      end
      if (exp_q.size() > 0) begin
        checks++;
        assert (win_obs === exp_q[0]) else begin
          errors++;
          $error("FAIL window obs=%h exp=%h", win_obs, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    checks = 0; errors = 0; got = 0; ready_mode = 1;
    reset = 1; in_valid = 0; in_sof = 0; in_pixel = '0; cfg = LWB'(4);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_win("reset_window", '0);

    cfg = LWB'(4);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = r * 4 + c;
    load_model(4, 4);
    g0 = got;
    send_frame(4, 4, 0);
    drain("w4_ramp");
    check_count("w4_ramp", 4);

    cfg = LWB'(1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) img[r][c] = r * 3 + c + 1;
    load_model(3, 3);
    g0 = got;
    send_frame(3, 3, 0);
    check_bit("clamp_latency", out_valid, 1'b1);
    drain("clamp");
    check_count("clamp", 1);

    cfg = LWB'(3);
    fill_random(3, 3);
    load_model(3, 3);
    ready_mode = 0;
    g0 = got;
    send_frame(3, 3, 0);
    snap = exp_q[0];
    repeat (5) begin
      @(negedge clk);
      check_bit("stall_in_ready", in_ready, 1'b0);
      check_bit("stall_out_valid", out_valid, 1'b1);
      check_win("stall_window", snap);
    end
    ready_mode = 1;
    drain("stall");
    check_count("stall", 1);

    cfg = LWB'(4);
    for (int k = 0; k < 6; k++) send_pix(200 + k, k == 0, 0);
    fill_random(4, 4);
    load_model(4, 4);
    g0 = got;
    send_frame(4, 4, 1);
    drain("mid_sof");
    check_count("mid_sof", 4);

    cfg = LWB'(3);
    fill_random(3, 3);
    load_model(3, 3);
    ready_mode = 0;
    send_frame(3, 3, 0);
    check_bit("pre_reset_valid", out_valid, 1'b1);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    check_bit("midrun_reset_valid", out_valid, 1'b0);
    check_bit("midrun_reset_ready", in_ready, 1'b1);
    check_win("midrun_reset_window", '0);
    exp_q.delete();
    ready_mode = 1;
    g0 = got;
    repeat (10) @(negedge clk);
    check_count("after_reset", 0);

    cfg = LWB'(32);
    fill_random(32, 8);
    load_model(32, 8);
    ready_mode = 2;
    g0 = got;
    send_frame(32, 8, 2);
    drain("random");
    check_count("random", 180);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, bits per grayscale pixel.
REQ-002 SHALL have parameter MAX_LINE_WIDTH, default 32, maximum pixels per image line.
REQ-003 SHALL have parameter LINE_WIDTH_BITS, default 6, width of the line-width configuration and column counter.
REQ-004 SHALL have ports:
  clk_i  input  1  clock, all logic on rising edge
  reset_i  input  1  synchronous reset, active-high
  cfg_width_i  input  LINE_WIDTH_BITS  active line width in pixels
  in_valid_i  input  1  input pixel valid
  in_sof_i  input  1  start of frame, qualifies pixel at (row 0, col 0)
  in_pixel_i  input  PIXEL_WIDTH  input grayscale pixel
  in_ready_o  output  1  block can accept a pixel
  out_valid_o  output  1  window valid
  out_ready_i  input  1  downstream (Sobel core stage) accepts window
  pix0_0_o .. pix2_2_o  output  PIXEL_WIDTH each  3x3 window; row 0 = oldest line, column 0 = leftmost (oldest) pixel.
REQ-005 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-006 SHALL accept a pixel when in_valid_i && in_ready_o at a rising edge.
REQ-007 SHALL drive in_ready_o = !out_valid_o || out_ready_i (combinational, single output stage).
REQ-008 SHALL hold col counter 0..W-1 and row counter saturating at 2; on accept col increments, at W-1 wraps to 0 and row increments.
REQ-009 SHALL latch W from cfg_width_i on each accepted sof pixel; W < 3 clamps to 3, W > MAX_LINE_WIDTH clamps to MAX_LINE_WIDTH; W held constant within a frame.
REQ-010 SHALL treat an accepted sof pixel as (row 0, col 0) regardless of counter state; counters continue from there.
REQ-011 SHALL keep two line memories indexed by col: on accept at col c, top = lineB[c], mid = lineA[c], bot = in_pixel_i; then lineB[c] <= lineA[c], lineA[c] <= in_pixel_i.
REQ-012 SHALL shift window registers one column left each accept and load {top, mid, bot} into column 2 (pix0_2, pix1_2, pix2_2).
REQ-013 SHALL assert out_valid_o the cycle after accepting a pixel with row == 2 and col >= 2 (latency 1 cycle); window then covers rows r-2..r, cols c-2..c.
REQ-014 SHALL produce no window for the first two rows or first two columns of a line (no border padding); output per frame = (W-2) x (H-2) windows.
REQ-015 SHALL hold window and out_valid_o stable while out_valid_o && !out_ready_i.
REQ-016 SHALL clear out_valid_o after a handshake cycle with no new accepted qualifying pixel; simultaneous handshake and accept of a qualifying pixel keeps out_valid_o high with the new window.
REQ-017 SHALL ignore in_pixel_i/in_sof_i when not accepted.
REQ-018 SHALL not disturb a pending output window on mid-frame sof; the new frame starts at the next accepted pixel.

Reset
REQ-019 SHALL on reset_i clear out_valid_o, all window outputs to 0, col, row, W to 3; in_ready_o = 1 the cycle after reset.
REQ-020 SHALL not reset line memories; row gating guarantees unwritten entries never reach a valid window.
REQ-021 SHALL drop any pending window on reset mid-operation; the next frame requires sof.

Structure
REQ-022 SHALL take PIXEL_WIDTH, MAX_LINE_WIDTH, LINE_WIDTH_BITS from shared package sobel_pkg, also used by the Sobel core stage.
REQ-023 SHALL implement each line memory as sub-module sobel_line_buffer (read-before-write at one index), instantiated twice.
REQ-024 SHALL map pix outputs directly onto the Sobel core pixel inputs with identical row/column meaning.

Verification
REQ-025 W=4, 4x4 frame pixels 0..15 row-major, out_ready_i=1 -> exactly 4 windows; first: rows {0,1,2},{4,5,6},{8,9,10}, last bottom-right 15.
REQ-026 cfg_width_i=1 -> W clamps to 3; 3x3 frame pixels 1..9 -> one window 1..9, out_valid_o one cycle after pixel 9 accepted.
REQ-027 out_ready_i=0 for 5 cycles with window pending -> in_ready_o=0, window unchanged; release -> same window accepted once, no loss/duplication.
REQ-028 sof asserted at pixel 6 of a W=4 frame -> no window until 2 rows + 3 pixels of new frame; first window contains only new-frame pixels.
REQ-029 reset_i pulsed with out_valid_o=1 -> next cycle out_valid_o=0, outputs 0, in_ready_o=1.
REQ-030 random in_valid_i/out_ready_i gaps, W=32, 8 lines -> window stream matches golden model 30x6 windows in order.
